// File: rtl/sim_run_controller.sv
// Run controller beside the core: sequences core reset, counts cycles/retirements and ends the run on a TOHOST store, a timeout or, with HANG_DETECT_EN, a hang.
// Exit is registered one edge after the triggering RUN cycle; it has no backpressure and every input is sampled each cycle.
module sim_run_controller #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CNT_W       = 32,
    parameter int                RST_CYCLES  = 4,
    parameter int                MAX_CYCLES  = 500,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h1000,
    parameter int                HANG_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              dmem_we_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic              retire_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              core_rst_o,
    output logic              running_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic              hang_o,
    output logic [DATA_W-1:0] exit_code_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  instret_o
);

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t            state_q;
    logic [RC_W-1:0]   rst_cnt_q;
    logic              core_rst_q;
    logic              running_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;
    logic              hang_q;
    logic [DATA_W-1:0] exit_code_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instret_q;

    logic [CNT_W-1:0]  cycle_d;
    logic [CNT_W-1:0]  instret_d;
    logic              tohost_hit;
    logic              timeout_hit;
    logic              hang_hit;

    always_comb begin
        cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
        instret_d = (retire_i && (instret_q != '1)) ? instret_q + CNT_W'(1) : instret_q;
    end

    assign tohost_hit  = dmem_we_i && (dmem_addr_i == TOHOST_ADDR) && dmem_wdata_i[0];
    assign timeout_hit = (cycle_d == CNT_W'(MAX_CYCLES));

`ifdef HANG_DETECT_EN
    localparam int HC_W = $clog2(HANG_CYCLES + 1);

    logic [ADDR_W-1:0] last_pc_q;
    logic              last_vld_q;
    logic [HC_W-1:0]   hcnt_q;
    logic [HC_W-1:0]   hcnt_d;

    // hcnt holds the length of the current same-pc streak; a new pc restarts it at this retirement.
    always_comb begin
        hcnt_d = (!last_vld_q || (pc_i == last_pc_q)) ? hcnt_q + HC_W'(1) : HC_W'(1);
    end

    assign hang_hit = retire_i && (hcnt_d == HC_W'(HANG_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i || (start_i && ((state_q == S_IDLE) || (state_q == S_DONE)))) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
            hcnt_q     <= '0;
        end else if ((state_q == S_RUN) && retire_i) begin
            last_pc_q  <= pc_i;
            last_vld_q <= 1'b1;
            hcnt_q     <= hcnt_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
    assign hang_hit  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            core_rst_q  <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hang_q      <= 1'b0;
            exit_code_q <= '0;
            cycle_q     <= '0;
            instret_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q     <= S_RESET;
                        rst_cnt_q   <= RC_W'(RST_CYCLES - 1);
                        core_rst_q  <= 1'b1;
                        running_q   <= 1'b0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        hang_q      <= 1'b0;
                        exit_code_q <= '0;
                        cycle_q     <= '0;
                        instret_q   <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_q    <= S_RUN;
                        core_rst_q <= 1'b0;
                        running_q  <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RC_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_q   <= cycle_d;
                    instret_q <= instret_d;
                    if (tohost_hit || hang_hit || timeout_hit) begin
                        state_q    <= S_DONE;
                        core_rst_q <= 1'b1;
                        running_q  <= 1'b0;
                        done_q     <= 1'b1;
                    end
                    // TOHOST outranks hang, which outranks timeout.
                    if (tohost_hit) begin
                        pass_q      <= (dmem_wdata_i == DATA_W'(1));
                        exit_code_q <= dmem_wdata_i >> 1;
                    end else if (hang_hit) begin
                        hang_q <= 1'b1;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_rst_o    = core_rst_q;
    assign running_o     = running_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign timeout_o     = timeout_q;
    assign hang_o        = hang_q;
    assign exit_code_o   = exit_code_q;
    assign cycle_count_o = cycle_q;
    assign instret_o     = instret_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: stimulus queues expected end-of-run results, a negedge monitor checks them when done rises.
module tb_sim_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        retire;
    logic [31:0] pc;
    logic        core_rst, running, done, pass, timeout, hang;
    logic [31:0] exit_code, cycle_count, instret;

    always #5 clk = ~clk;

    sim_run_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dmem_we_i     (dmem_we),
        .dmem_addr_i   (dmem_addr),
        .dmem_wdata_i  (dmem_wdata),
        .retire_i      (retire),
        .pc_i          (pc),
        .core_rst_o    (core_rst),
        .running_o     (running),
        .done_o        (done),
        .pass_o        (pass),
        .timeout_o     (timeout),
        .hang_o        (hang),
        .exit_code_o   (exit_code),
        .cycle_count_o (cycle_count),
        .instret_o     (instret)
    );

    typedef struct {
        logic        pass;
        logic        tmo;
        logic        hang;
        logic [31:0] code;
        logic [31:0] cyc;
        logic [31:0] inst;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic t, input logic h,
                            input logic [31:0] code, input logic [31:0] cyc, input logic [31:0] inst);
        exp_t e;
        e.pass = p; e.tmo = t; e.hang = h; e.code = code; e.cyc = cyc; e.inst = inst;
        expq.push_back(e);
    endtask

    // Monitor: compares the oldest expectation against the outputs when done rises.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (expq.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("pass",        32'(pass),    32'(e.pass));
                    check("timeout",     32'(timeout), 32'(e.tmo));
                    check("hang",        32'(hang),    32'(e.hang));
                    check("exit_code",   exit_code,    e.code);
                    check("cycle_count", cycle_count,  e.cyc);
                    check("instret",     instret,      e.inst);
                    check("done_core_rst", 32'(core_rst), 32'd1);
                    check("done_running",  32'(running),  32'd0);
                end
            end
            done_prev = done;
        end
    end

    task automatic clear_inputs();
        start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0; retire = 1'b0; pc = '0;
    endtask

    // Pulses start and measures how long core_rst stays high before running rises.
    task automatic start_run(input bit noisy);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (noisy) begin
            retire = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h1000; dmem_wdata = 32'h1;
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (running) begin
                seen = 1'b1;
                break;
            end
            if (core_rst) n++;
            @(negedge clk);
        end
        clear_inputs();
        check("run_reached", 32'(seen), 32'd1);
        check("core_rst_len", n, 32'd4);
        check("core_rst_in_run", 32'(core_rst), 32'd0);
    endtask

    // retire_mode: 0 none, 1 every cycle, 2 odd cycles. pc_mode: 0 k*4, 1 constant 'h40, 2 alternating.
    task automatic run_until_done(input int store_cyc, input logic [31:0] store_dat,
                                  input int retire_mode, input int pc_mode, input int watch_cyc);
        bit fin;
        fin = 1'b0;
        for (int k = 1; k <= 700; k++) begin
            dmem_we    = 1'b0;
            dmem_addr  = 32'h1000;
            dmem_wdata = store_dat;
            if (k == store_cyc) begin
                dmem_we = 1'b1;
            end else if ((store_cyc > 2) && (k == store_cyc - 1)) begin
                dmem_we = 1'b1; dmem_addr = 32'h1004; dmem_wdata = 32'h1;
            end else if (k == watch_cyc) begin
                dmem_we = 1'b1; dmem_wdata = 32'h6;
            end
            retire = (retire_mode == 1) || ((retire_mode == 2) && (k % 2 == 1));
            pc = (pc_mode == 0) ? 32'(k * 4) : (pc_mode == 1) ? 32'h40 : ((k % 2 == 1) ? 32'h44 : 32'h40);
            @(negedge clk);
            if (k == watch_cyc) begin
                check("ignored_store_running", 32'(running), 32'd1);
                check("ignored_store_done",    32'(done),    32'd0);
            end
            if (done) begin
                fin = 1'b1;
                break;
            end
        end
        clear_inputs();
        if (!fin) check("run_bound", 32'd0, 32'd1);
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_core_rst",  32'(core_rst), 32'd1);
        check("rst_running",   32'(running),  32'd0);
        check("rst_done",      32'(done),     32'd0);
        check("rst_pass",      32'(pass),     32'd0);
        check("rst_timeout",   32'(timeout),  32'd0);
        check("rst_hang",      32'(hang),     32'd0);
        check("rst_exit_code", exit_code,     32'd0);
        check("rst_cycles",    cycle_count,   32'd0);
        check("rst_instret",   instret,       32'd0);
        rst = 1'b0;

        // Pass on cycle 20; retire and TOHOST noise during RESET must be ignored.
        push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd20, 32'd20);
        start_run(1'b1);
        run_until_done(20, 32'h1, 1, 0, 0);

        // Re-run from DONE: fail code 7 -> exit_code 3, no retirements.
        push_exp(1'b0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0);
        start_run(1'b0);
        run_until_done(5, 32'h7, 0, 0, 0);

        // Store of 6 on cycle 3 and wrong-address store are ignored; pass on cycle 8.
        push_exp(1'b1, 1'b0, 1'b0, 32'd0, 32'd8, 32'd4);
        start_run(1'b0);
        run_until_done(8, 32'h1, 2, 0, 3);

        // No TOHOST, alternating pc: timeout after exactly 500 cycles.
        push_exp(1'b0, 1'b1, 1'b0, 32'd0, 32'd500, 32'd500);
        start_run(1'b0);
        run_until_done(0, 32'h0, 1, 2, 0);

        // Constant pc every cycle.
`ifdef HANG_DETECT_EN
        push_exp(1'b0, 1'b0, 1'b1, 32'd0, 32'd16, 32'd16);
`else
        push_exp(1'b0, 1'b1, 1'b0, 32'd0, 32'd500, 32'd500);
`endif
        start_run(1'b0);
        run_until_done(0, 32'h0, 1, 1, 0);

        // rst during RUN cycle 10 returns to IDLE with counters cleared.
        start_run(1'b0);
        retire = 1'b1;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        retire = 1'b0;
        check("midrst_core_rst", 32'(core_rst), 32'd1);
        check("midrst_running",  32'(running),  32'd0);
        check("midrst_done",     32'(done),     32'd0);
        check("midrst_cycles",   cycle_count,   32'd0);
        check("midrst_instret",  instret,       32'd0);

        // Start from IDLE, exit on the very first RUN cycle.
        push_exp(1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd1);
        start_run(1'b0);
        run_until_done(1, 32'h3, 1, 0, 0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
